mseq_sync_ctrl: RTL and testbench

//  Frame-sync controller that sequences the m-sequence decoder (dec).

---
 rtl/mseq_sync_ctrl.sv | 135 +++++++++++++
 tb/tb_mseq_sync_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mseq_sync_ctrl.sv
// Frame-sync controller for the m-sequence decoder: acquires and tracks frame timing from
// per-chip correlation scores, and packs per-frame polarity bits into bytes (MSB first).
module mseq_sync_ctrl #(
    parameter int unsigned LEN      = 31,
    parameter int unsigned SW       = 6,
    parameter int unsigned THRESH   = 28,
    parameter int unsigned VERIFY_N = 2,
    parameter int unsigned MISS_N   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [SW-1:0]           score,
    output logic                    dec_clr,
    output logic                    lock,
    output logic                    frame_stb,
    output logic [$clog2(LEN)-1:0]  phase,
    output logic [7:0]              data,
    output logic                    data_vld
);

    localparam int unsigned PW = $clog2(LEN);
    localparam int unsigned VW = $clog2(VERIFY_N + 1);
    localparam int unsigned MW = $clog2(MISS_N + 1);

    localparam logic [SW-1:0] LEN_S   = SW'(LEN);
    localparam logic [SW-1:0] THR_S   = SW'(THRESH);
    localparam logic [SW-1:0] NEG_S   = SW'(LEN - THRESH);
    localparam logic [PW-1:0] PH_LAST = PW'(LEN - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(VERIFY_N - 1);
    localparam logic [MW-1:0] M_LAST  = MW'(MISS_N - 1);

    typedef enum logic [1:0] {StSearch, StVerify, StLock} state_e;

    state_e        state;
    logic [VW-1:0] vcnt;
    logic [MW-1:0] miss;
    logic [2:0]    bitcnt;
    logic [6:0]    shift;

    logic [SW-1:0] sc;
    logic          pos_pk;
    logic          neg_pk;
    logic          pk;
    logic          expct;
    logic [PW-1:0] phase_nxt;

    always_comb begin
        sc        = (score > LEN_S) ? LEN_S : score;
        pos_pk    = (sc >= THR_S);
        neg_pk    = (sc <= NEG_S);
        pk        = pos_pk | neg_pk;
        expct     = (phase == PH_LAST);
        // Wrapping to 0 on the expected boundary doubles as the accepted-boundary reset.
        phase_nxt = expct ? '0 : phase + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StSearch;
            vcnt      <= '0;
            miss      <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            phase     <= '0;
            data      <= '0;
            lock      <= 1'b0;
            dec_clr   <= 1'b0;
            frame_stb <= 1'b0;
            data_vld  <= 1'b0;
        end else begin
            dec_clr   <= 1'b0;
            frame_stb <= 1'b0;
            data_vld  <= 1'b0;
            if (en) begin
                phase <= phase_nxt;
                unique case (state)
                    StSearch: begin
                        if (pk) begin
                            phase <= '0;
                            vcnt  <= '0;
                            state <= StVerify;
                        end
                    end
                    StVerify: begin
                        if (expct) begin
                            if (pk) begin
                                vcnt <= vcnt + 1'b1;
                                if (vcnt == V_LAST) begin
                                    state  <= StLock;
                                    lock   <= 1'b1;
                                    miss   <= '0;
                                    bitcnt <= '0;
                                    shift  <= '0;
                                end
                            end else begin
                                state   <= StSearch;
                                dec_clr <= 1'b1;
                            end
                        end
                    end
                    StLock: begin
                        if (expct) begin
                            frame_stb <= 1'b1;
                            if (pk) begin
                                miss <= '0;
                                if (bitcnt == 3'd7) begin
                                    data     <= {shift, pos_pk};
                                    data_vld <= 1'b1;
                                    bitcnt   <= '0;
                                    shift    <= '0;
                                end else begin
                                    shift  <= {shift[5:0], pos_pk};
                                    bitcnt <= bitcnt + 1'b1;
                                end
                            end else begin
                                miss <= miss + 1'b1;
                                if (miss == M_LAST) begin
                                    state   <= StSearch;
                                    lock    <= 1'b0;
                                    dec_clr <= 1'b1;
                                    miss    <= '0;
                                    bitcnt  <= '0;
                                    shift   <= '0;
                                end
                            end
                        end
                    end
                    default: state <= StSearch;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mseq_sync_ctrl.sv
// Directed bench for mseq_sync_ctrl: acquisition, byte assembly, loss of sync,
// false start, en gating and mid-byte reset.
module tb_mseq_sync_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [5:0] score = '0;
    logic       dec_clr;
    logic       lock;
    logic       frame_stb;
    logic [4:0] phase;
    logic [7:0] data;
    logic       data_vld;

    int total = 0;
    int bad = 0;
    int spur = 0;
    int nvld = 0;

    mseq_sync_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .score     (score),
        .dec_clr   (dec_clr),
        .lock      (lock),
        .frame_stb (frame_stb),
        .phase     (phase),
        .data      (data),
        .data_vld  (data_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One clock with the given inputs; outputs are sampled 1ns after the edge.
    task automatic step(input logic e, input logic [5:0] s);
        en    = e;
        score = s;
        @(posedge clk);
        #1;
        nvld += int'(data_vld);
    endtask

    // 30 non-peak chips then the expected-boundary chip with score s.
    task automatic frame(input logic [5:0] s);
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 6'd15);
            if (frame_stb || data_vld || dec_clr) spur++;
        end
        step(1'b1, s);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        score = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        spur  = 0;
        nvld  = 0;
    endtask

    task automatic acquire();
        step(1'b1, 6'd31);
        frame(6'd31);
        check("acq_verify_no_lock", 32'(lock), 0);
        frame(6'd31);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_lock"}, 32'(lock), 0);
        check({tag, "_phase"}, 32'(phase), 0);
        check({tag, "_data"}, 32'(data), 0);
        check({tag, "_pulses"}, 32'({dec_clr, frame_stb, data_vld}), 0);
    endtask

    initial begin
        // Reset state
        #3;
        check_zero("reset");
        do_reset();

        // 1 Acquire: lock after chip 62, frame_stb at 93 and 124
        acquire();
        check("t1_lock", 32'(lock), 1);
        check("t1_phase0", 32'(phase), 0);
        check("t1_stb_at_lock", 32'(frame_stb), 0);
        frame(6'd31);
        check("t1_stb93", 32'(frame_stb), 1);
        check("t1_phase_wrap", 32'(phase), 0);
        step(1'b1, 6'd15);
        check("t1_stb_one_cycle", 32'(frame_stb), 0);
        check("t1_phase1", 32'(phase), 1);
        for (int i = 0; i < 29; i++) step(1'b1, 6'd15);
        step(1'b1, 6'd31);
        check("t1_stb124", 32'(frame_stb), 1);
        check("t1_spur", spur, 0);

        // 2 Data: +,-,+,+,-,-,+,- -> 8'hB2
        do_reset();
        acquire();
        nvld = 0;
        frame(6'd31); frame(6'd0); frame(6'd31); frame(6'd31);
        frame(6'd0);  frame(6'd0); frame(6'd31);
        check("t2_no_early_vld", nvld, 0);
        frame(6'd0);
        check("t2_vld", 32'(data_vld), 1);
        check("t2_data", 32'(data), 32'hB2);
        step(1'b1, 6'd15);
        check("t2_vld_pulse", 32'(data_vld), 0);
        check("t2_data_hold", 32'(data), 32'hB2);
        check("t2_vld_count", nvld, 1);
        check("t2_spur", spur, 0);

        // 3 Loss: three misses drop lock; a peak resets the miss count
        do_reset();
        acquire();
        frame(6'd15); frame(6'd15); frame(6'd31);
        check("t3_keep_lock", 32'(lock), 1);
        frame(6'd15); frame(6'd15);
        check("t3_two_miss_lock", 32'(lock), 1);
        check("t3_two_miss_noclr", 32'(dec_clr), 0);
        frame(6'd15);
        check("t3_lost", 32'(lock), 0);
        check("t3_clr", 32'(dec_clr), 1);
        check("t3_stb_on_miss", 32'(frame_stb), 1);
        step(1'b1, 6'd15);
        check("t3_clr_pulse", 32'(dec_clr), 0);
        check("t3_spur", spur, 0);

        // 4 False start: off-boundary peak ignored, non-peak at boundary aborts
        do_reset();
        step(1'b1, 6'd31);
        for (int i = 1; i < 10; i++) step(1'b1, 6'd15);
        step(1'b1, 6'd31);
        for (int i = 11; i < 31; i++) step(1'b1, 6'd15);
        check("t4_no_clr_yet", 32'(dec_clr), 0);
        step(1'b1, 6'd20);
        check("t4_clr", 32'(dec_clr), 1);
        check("t4_no_lock", 32'(lock), 0);
        frame(6'd31);
        check("t4_still_no_lock", 32'(lock), 0);

        // 5 en gating: 5 idle cycles mid-frame delay the boundary by 5 clks
        do_reset();
        acquire();
        for (int i = 0; i < 10; i++) step(1'b1, 6'd15);
        check("t5_phase10", 32'(phase), 10);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 6'd31);
            if (frame_stb || data_vld || dec_clr) spur++;
        end
        check("t5_phase_hold", 32'(phase), 10);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 6'd15);
            if (frame_stb || data_vld || dec_clr) spur++;
        end
        check("t5_phase30", 32'(phase), 30);
        step(1'b1, 6'd31);
        check("t5_stb", 32'(frame_stb), 1);
        check("t5_lock", 32'(lock), 1);
        check("t5_spur", spur, 0);

        // 6 Reset mid-byte: partial bits discarded
        do_reset();
        acquire();
        for (int i = 0; i < 5; i++) frame(6'd31);
        for (int i = 0; i < 10; i++) step(1'b1, 6'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        do_reset();
        acquire();
        for (int i = 0; i < 7; i++) frame(6'd0);
        frame(6'd31);
        check("t6_vld", 32'(data_vld), 1);
        check("t6_data", 32'(data), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
